// File: rtl/pe_row_seq_ctrl.sv
// Sequencer for one PE row: loads one config word per unit (LSU, PE_0..PE_3) through an
// init pulse each, then sweeps run_sel round-robin for a programmed number of iterations.
module pe_row_seq_ctrl #(
  parameter int unsigned INST_W  = 64,
  parameter int unsigned CFG_AW  = 8,
  parameter int unsigned ITER_W  = 16,
  parameter int unsigned N_UNITS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CFG_AW-1:0] cfg_base,
  input  logic [ITER_W-1:0] iter_total,
  output logic              cfg_rd_en,
  output logic [CFG_AW-1:0] cfg_addr,
  input  logic [INST_W-1:0] cfg_rdata,
  output logic [INST_W-1:0] pe_config,
  output logic              init_en,
  output logic [2:0]        init_sel,
  output logic              run_en,
  output logic [2:0]        run_sel,
  output logic              busy,
  output logic              done
);

  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] LAST_UNIT = SEL_W'(N_UNITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_INIT = 3'd3,
    ST_RUN  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  state_e              state_q;
  logic [CFG_AW-1:0]   base_q;
  logic [ITER_W-1:0]   iter_q;
  logic [SEL_W-1:0]    u_q;
  logic [SEL_W-1:0]    s_q;
  logic [ITER_W-1:0]   it_q;
  logic                rd_en_q;
  logic [CFG_AW-1:0]   addr_q;
  logic [INST_W-1:0]   pe_cfg_q;
  logic                init_en_q;
  logic [SEL_W-1:0]    init_sel_q;
  logic                run_en_q;
  logic [SEL_W-1:0]    run_sel_q;
  logic                busy_q;
  logic                done_q;

  // Outputs are registered: each transition sets the strobes for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      iter_q     <= '0;
      u_q        <= '0;
      s_q        <= '0;
      it_q       <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      pe_cfg_q   <= '0;
      init_en_q  <= 1'b0;
      init_sel_q <= '0;
      run_en_q   <= 1'b0;
      run_sel_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (abort) begin
      // Abort beats start in IDLE and silently drops any sequence in flight.
      state_q   <= ST_IDLE;
      u_q       <= '0;
      s_q       <= '0;
      it_q      <= '0;
      rd_en_q   <= 1'b0;
      init_en_q <= 1'b0;
      run_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RD;
            base_q  <= cfg_base;
            iter_q  <= iter_total;
            u_q     <= '0;
            rd_en_q <= 1'b1;
            addr_q  <= cfg_base;
            busy_q  <= 1'b1;
          end
        end
        ST_RD: begin
          rd_en_q <= 1'b0;
          state_q <= ST_CAP;
        end
        ST_CAP: begin
          pe_cfg_q   <= cfg_rdata;
          init_en_q  <= 1'b1;
          init_sel_q <= u_q;
          state_q    <= ST_INIT;
        end
        ST_INIT: begin
          init_en_q <= 1'b0;
          if (u_q != LAST_UNIT) begin
            u_q     <= u_q + SEL_W'(1);
            rd_en_q <= 1'b1;
            addr_q  <= base_q + CFG_AW'(u_q) + CFG_AW'(1);
            state_q <= ST_RD;
          end else if (iter_q != '0) begin
            s_q       <= '0;
            it_q      <= '0;
            run_en_q  <= 1'b1;
            run_sel_q <= '0;
            state_q   <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_RUN: begin
          if (s_q == LAST_UNIT) begin
            // it_q stays below iter_q, so the increment cannot wrap even at max count.
            it_q <= it_q + ITER_W'(1);
            s_q  <= '0;
            if (it_q + ITER_W'(1) == iter_q) begin
              run_en_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              run_sel_q <= '0;
            end
          end else begin
            s_q       <= s_q + SEL_W'(1);
            run_sel_q <= s_q + SEL_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_rd_en = rd_en_q;
  assign cfg_addr  = addr_q;
  assign pe_config = pe_cfg_q;
  assign init_en   = init_en_q;
  assign init_sel  = init_sel_q;
  assign run_en    = run_en_q;
  assign run_sel   = run_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pe_row_seq_ctrl.sv
// Self-checking bench for pe_row_seq_ctrl: a cycle-indexed timeline model of the sequence
// (reads, inits, run sweeps, done) is compared against the DUT every cycle.
module tb_pe_row_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  cfg_base;
  logic [15:0] iter_total;
  logic        cfg_rd_en;
  logic [7:0]  cfg_addr;
  logic [63:0] cfg_rdata;
  logic [63:0] pe_config;
  logic        init_en;
  logic [2:0]  init_sel;
  logic        run_en;
  logic [2:0]  run_sel;
  logic        busy, done;

  logic [63:0] mem [256];
  logic [63:0] last_cfg;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pe_row_seq_ctrl #(.INST_W(64), .CFG_AW(8), .ITER_W(16), .N_UNITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_base(cfg_base), .iter_total(iter_total),
    .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr), .cfg_rdata(cfg_rdata),
    .pe_config(pe_config), .init_en(init_en), .init_sel(init_sel),
    .run_en(run_en), .run_sel(run_sel), .busy(busy), .done(done)
  );

  // Config memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (cfg_rd_en) cfg_rdata <= mem[cfg_addr];
    else           cfg_rdata <= {$urandom, $urandom};
  end

  // Cycle c is the cycle following clock edge c-1; start is sampled at edge 0.
  task automatic run_seq(input logic [7:0] base, input logic [15:0] iters,
                         input int abort_cyc, input int stray_cyc, input string tag);
    int end_c, last_c;
    logic e_rd, e_init, e_run, e_busy, e_done;
    logic [7:0]  e_addr;
    logic [2:0]  e_isel, e_rsel;
    logic [63:0] e_cfg;
    end_c  = (iters == 16'd0) ? 16 : 16 + 5 * int'(iters);
    last_c = ((abort_cyc > 0) ? abort_cyc : end_c) + 2;
    e_cfg  = last_cfg;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; cfg_base = base; iter_total = iters;
    @(posedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      e_rd   = (c <= 15) && (c % 3 == 1);
      e_init = (c <= 15) && (c % 3 == 0);
      e_run  = (iters != 16'd0) && (c >= 16) && (c < end_c);
      e_done = (c == end_c);
      e_busy = (c < end_c);
      e_addr = 8'(int'(base) + (c - 1) / 3);
      e_isel = 3'(c / 3 - 1);
      e_rsel = 3'((c - 16) % 5);
      if (abort_cyc > 0 && c > abort_cyc) begin
        e_rd = 1'b0; e_init = 1'b0; e_run = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      end
      e_cfg = last_cfg;
      for (int k = 0; k < 5; k++)
        if (3 * k + 3 <= c && (abort_cyc <= 0 || 3 * k + 2 < abort_cyc))
          e_cfg = mem[8'(int'(base) + k)];
      checks++;
      if ({cfg_rd_en, init_en, run_en, busy, done} !== {e_rd, e_init, e_run, e_busy, e_done}) begin
        errors++;
        $display("FAIL %s strobes(rd,init,run,busy,done) cycle %0d: got %b expected %b", tag, c,
                 {cfg_rd_en, init_en, run_en, busy, done}, {e_rd, e_init, e_run, e_busy, e_done});
      end
      checks++;
      if (pe_config !== e_cfg) begin
        errors++;
        $display("FAIL %s pe_config cycle %0d: got %h expected %h", tag, c, pe_config, e_cfg);
      end
      if (e_rd) begin
        checks++;
        if (cfg_addr !== e_addr) begin
          errors++;
          $display("FAIL %s cfg_addr cycle %0d: got %h expected %h", tag, c, cfg_addr, e_addr);
        end
      end
      if (e_init) begin
        checks++;
        if (init_sel !== e_isel) begin
          errors++;
          $display("FAIL %s init_sel cycle %0d: got %0d expected %0d", tag, c, init_sel, e_isel);
        end
      end
      if (e_run) begin
        checks++;
        if (run_sel !== e_rsel) begin
          errors++;
          $display("FAIL %s run_sel cycle %0d: got %0d expected %0d", tag, c, run_sel, e_rsel);
        end
      end
      start = (c == stray_cyc);
      abort = (c == abort_cyc);
      @(posedge clk);
    end
    last_cfg = e_cfg;
  endtask

  task automatic test_reset();
    logic [82:0] v;
    rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_base = '0; iter_total = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = {cfg_rd_en, cfg_addr, pe_config, init_en, init_sel, run_en, run_sel, busy, done};
    checks++;
    if (v !== 83'd0) begin
      errors++;
      $display("FAIL reset outputs: got %h expected 0", v);
    end
    rst = 1'b0;
    last_cfg = '0;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 5; k++) mem[8'h10 + k] = 64'hA0 + 64'(k);
    run_seq(8'h10, 16'd2, -1, -1, "basic");
  endtask

  task automatic test_zero_iter();
    run_seq(8'h10, 16'd0, -1, -1, "zero_iter");
    checks++;
    if (pe_config !== 64'hA4) begin
      errors++;
      $display("FAIL zero_iter held pe_config: got %h expected a4", pe_config);
    end
  endtask

  task automatic test_addr_wrap();
    run_seq(8'hFE, 16'd1, -1, -1, "addr_wrap");
  endtask

  task automatic test_abort();
    run_seq(8'h10, 16'd2, 8, -1, "abort");
    run_seq(8'h40, 16'd1, -1, -1, "restart");
  endtask

  task automatic test_ignored_start();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; cfg_base = 8'h33; iter_total = 16'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({cfg_rd_en, init_en, run_en, busy, done} !== 5'b0) begin
        errors++;
        $display("FAIL start_abort_idle cycle %0d: got %b expected 00000", i,
                 {cfg_rd_en, init_en, run_en, busy, done});
      end
      @(negedge clk);
    end
    run_seq(8'h20, 16'd3, -1, 20, "stray_start");
  endtask

  task automatic test_rst_mid_run();
    logic [82:0] v;
    @(negedge clk);
    start = 1'b1; cfg_base = 8'h50; iter_total = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    checks++;
    if (run_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_run pre-reset run_en: got %b expected 1", run_en);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v = {cfg_rd_en, cfg_addr, pe_config, init_en, init_sel, run_en, run_sel, busy, done};
    checks++;
    if (v !== 83'd0) begin
      errors++;
      $display("FAIL rst_mid_run outputs: got %h expected 0", v);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({cfg_rd_en, init_en, run_en, busy, done} !== 5'b0) begin
        errors++;
        $display("FAIL rst_mid_run idle %0d: got %b expected 00000", i,
                 {cfg_rd_en, init_en, run_en, busy, done});
      end
    end
    last_cfg = '0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [7:0]  b;
      logic [15:0] it;
      int end_c, ab, st;
      b     = 8'($urandom);
      it    = 16'($urandom_range(0, 4));
      end_c = (it == 16'd0) ? 16 : 16 + 5 * int'(it);
      ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, end_c - 1)) : -1;
      st    = (ab < 0 && it != 16'd0) ? int'($urandom_range(16, end_c - 1)) : -1;
      run_seq(b, it, ab, st, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_seq(8'h80, 16'd1, -1, -1, "b2b_first");
    run_seq(8'h85, 16'd2, -1, -1, "b2b_second");
  endtask

  task automatic test_max_iter();
    run_seq(8'($urandom), 16'hFFFF, 16 + 5 * 20 + 3, -1, "max_iter");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_basic();
    test_zero_iter();
    test_addr_wrap();
    test_abort();
    test_ignored_start();
    test_rst_mid_run();
    test_random();
    test_back_to_back();
    test_max_iter();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
